// File: rtl/jtag_pkg.sv
// Shared op codes, FSM state encoding and TAP constants for the JTAG host driver.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_SHIFT_IR = 2'd1,
    OP_SHIFT_DR = 2'd2,
    OP_IDLE     = 2'd3
  } jtag_op_e;

  // ST_TLR is the commanded TAP reset; ST_RUN is the commanded Run-Test/Idle dwell.
  typedef enum logic [3:0] {
    ST_SYNC,
    ST_IDLE,
    ST_TLR,
    ST_RUN,
    ST_SEL,
    ST_CAP,
    ST_ENTER,
    ST_SHIFT,
    ST_UPD,
    ST_RET
  } jtag_state_e;

  localparam int RESET_TCKS = 5;

endpackage

// File: rtl/jtag_host_driver_if.sv
// Command/response bus of the JTAG host driver (master = command issuer, slave = driver).
interface jtag_host_driver_if #(
  parameter int MAX_LEN = 32
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: 2*TCK_HALF clk per tck, with one-clk strobes on the edges where tck rises/falls.
module jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int CW = (2 * TCK_HALF > 2) ? $clog2(2 * TCK_HALF) : 1;

  logic [CW-1:0] cnt;

  assign rise_stb = run && (cnt == CW'(TCK_HALF - 1));
  assign fall_stb = run && (cnt == CW'(2 * TCK_HALF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= fall_stb ? '0 : cnt + CW'(1);
      if (rise_stb)      tck <= 1'b1;
      else if (fall_stb) tck <= 1'b0;
    end
  end

endmodule

// File: rtl/jtag_host_driver.sv
// JTAG master: runs RESET / SHIFT_IR / SHIFT_DR / IDLE commands against a TAP from Run-Test/Idle.
// Optional JTAG_TRST_EN adds an active-low trst_n held low during reset, sync and RESET ops.
module jtag_host_driver
  import jtag_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  jtag_host_driver_if.slave bus,
  output logic tck,
  output logic tms,
  output logic tdi,
  input  logic tdo
`ifdef JTAG_TRST_EN
  , output logic trst_n
`endif
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

  jtag_state_e        state_q, state_n;
  jtag_op_e           op_q, op_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [MAX_LEN-1:0] data_q, data_n, cap_q, cap_n, rsp_n;
  logic               tms_n, tdi_n, done, run, rise_stb, fall_stb;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)               return LEN_W'(1);
    if (l > LEN_W'(MAX_LEN))   return LEN_W'(MAX_LEN);
    return l;
  endfunction

  function automatic logic tms_of(input jtag_state_e s, input logic [CNT_W-1:0] c,
                                  input logic [LEN_W-1:0] l);
    case (s)
      ST_SYNC, ST_TLR: return c < CNT_W'(RESET_TCKS);
      ST_SEL, ST_UPD:  return 1'b1;
      ST_SHIFT:        return c == CNT_W'(l) - CNT_W'(1);
      default:         return 1'b0;
    endcase
  endfunction

  assign run = (state_q != ST_IDLE);

  jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = ~bus.cmd_ready;

  // State and counters only move on the accept edge or a tck falling edge,
  // so tms/tdi registered from the next-state values change only there.
  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    cnt_n   = cnt_q;
    len_n   = len_q;
    data_n  = data_q;
    cap_n   = cap_q;
    done    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.cmd_valid) begin
        op_n   = jtag_op_e'(bus.cmd_op);
        len_n  = clamp_len(bus.cmd_len);
        data_n = bus.cmd_data;
        cap_n  = '0;
        cnt_n  = '0;
        case (jtag_op_e'(bus.cmd_op))
          OP_RESET: state_n = ST_TLR;
          OP_IDLE:  state_n = ST_RUN;
          default:  state_n = ST_SEL;
        endcase
      end
    end else begin
      if (rise_stb && state_q == ST_SHIFT) cap_n = {tdo, cap_q[MAX_LEN-1:1]};
      if (fall_stb) begin
        cnt_n = cnt_q + CNT_W'(1);
        case (state_q)
          ST_SYNC, ST_TLR: if (cnt_q == CNT_W'(RESET_TCKS)) begin
            state_n = ST_IDLE;
            done    = (state_q == ST_TLR);
          end
          ST_RUN: if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin
            state_n = ST_IDLE;
            done    = 1'b1;
          end
          ST_SEL: if (op_q == OP_SHIFT_DR || cnt_q == CNT_W'(1)) state_n = ST_CAP;
          ST_CAP:   state_n = ST_ENTER;
          ST_ENTER: state_n = ST_SHIFT;
          ST_SHIFT: begin
            data_n = data_q >> 1;
            if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) state_n = ST_UPD;
          end
          ST_UPD: state_n = ST_RET;
          ST_RET: begin
            state_n = ST_IDLE;
            done    = 1'b1;
          end
          default: state_n = ST_IDLE;
        endcase
        if (state_n != state_q) cnt_n = '0;
      end
    end
    tms_n = tms_of(state_n, cnt_n, len_n);
    tdi_n = (state_n == ST_SHIFT) ? data_n[0] : 1'b0;
    // Captured bits enter at the MSB; right-align so bit0 is the first captured bit.
    rsp_n = (op_q == OP_SHIFT_IR || op_q == OP_SHIFT_DR) ?
            (cap_q >> (LEN_W'(MAX_LEN) - len_q)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      op_q          <= OP_RESET;
      cnt_q         <= '0;
      len_q         <= '0;
      data_q        <= '0;
      cap_q         <= '0;
      tms           <= 1'b1;
      tdi           <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      state_q       <= state_n;
      op_q          <= op_n;
      cnt_q         <= cnt_n;
      len_q         <= len_n;
      data_q        <= data_n;
      cap_q         <= cap_n;
      tms           <= tms_n;
      tdi           <= tdi_n;
      bus.rsp_valid <= done;
      if (done) bus.rsp_data <= rsp_n;
    end
  end

`ifdef JTAG_TRST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trst_n <= 1'b0;
    else     trst_n <= !(state_n == ST_SYNC || state_n == ST_TLR);
  end
`endif

endmodule

// File: tb/tb_jtag_host_driver.sv
// Randomized bench for jtag_host_driver against a behavioural TAP and op-sequence reference.
module tb_jtag_host_driver;
  import jtag_pkg::*;

  localparam int MAX_LEN  = 32;
  localparam int TCK_HALF = 2;
  localparam int LEN_W    = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck, tms, tdi;
  logic tdo = 1'b0;
`ifdef JTAG_TRST_EN
  logic trst_n;
`endif

  jtag_host_driver_if #(.MAX_LEN(MAX_LEN)) bus ();

  jtag_host_driver #(.MAX_LEN(MAX_LEN), .TCK_HALF(TCK_HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tck (tck),
    .tms (tms),
    .tdi (tdi),
    .tdo (tdo)
`ifdef JTAG_TRST_EN
    , .trst_n (trst_n)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, nacc = 0, nrsp = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cmd_valid && bus.cmd_ready) nacc <= nacc + 1;
    if (bus.rsp_valid) nrsp <= nrsp + 1;
  end

  // Record tms/tdi seen by the device at every rising tck.
  logic [63:0] rec_tms = '0, rec_tdi = '0;
  int rec_n = 0;
  always @(posedge tck) begin
    if (rec_n < 64) begin
      rec_tms[rec_n] = tms;
      rec_tdi[rec_n] = tdi;
    end
    rec_n = rec_n + 1;
  end

  // Behavioural IEEE 1149.1 TAP: 2-bit IR (captures 01, TLR loads 01), DR is a 1-bit BYPASS.
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDS, T_CDR, T_SHDR, T_E1D, T_PDR, T_E2D, T_UDR,
    T_SIS, T_CIR, T_SHIR, T_E1I, T_PIR, T_E2I, T_UIR
  } tap_e;
  tap_e ts = T_TLR;
  logic [1:0] ir = 2'b01, ir_sr = 2'b01, exp_ir = 2'b01;
  logic bp = 1'b0;

  always @(posedge tck) begin
    case (ts)
      T_CDR:  bp <= 1'b0;
      T_SHDR: bp <= tdi;
      T_CIR:  ir_sr <= 2'b01;
      T_SHIR: ir_sr <= {tdi, ir_sr[1]};
      default: ;
    endcase
    case (ts)
      T_TLR:  ts <= tms ? T_TLR : T_RTI;
      T_RTI:  ts <= tms ? T_SDS : T_RTI;
      T_SDS:  ts <= tms ? T_SIS : T_CDR;
      T_CDR:  ts <= tms ? T_E1D : T_SHDR;
      T_SHDR: ts <= tms ? T_E1D : T_SHDR;
      T_E1D:  ts <= tms ? T_UDR : T_PDR;
      T_PDR:  ts <= tms ? T_E2D : T_PDR;
      T_E2D:  ts <= tms ? T_UDR : T_SHDR;
      T_UDR:  ts <= tms ? T_SDS : T_RTI;
      T_SIS:  ts <= tms ? T_TLR : T_CIR;
      T_CIR:  ts <= tms ? T_E1I : T_SHIR;
      T_SHIR: ts <= tms ? T_E1I : T_SHIR;
      T_E1I:  ts <= tms ? T_UIR : T_PIR;
      T_PIR:  ts <= tms ? T_E2I : T_PIR;
      T_E2I:  ts <= tms ? T_UIR : T_SHIR;
      default: ts <= tms ? T_SDS : T_RTI;
    endcase
  end

  always @(negedge tck) begin
    tdo <= (ts == T_SHDR) ? bp : (ts == T_SHIR) ? ir_sr[0] : 1'b0;
    if (ts == T_UIR) ir <= ir_sr;
    if (ts == T_TLR) ir <= 2'b01;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_tck"}, 64'(tck), 64'd0);
    chk({tag, "_tms"}, 64'(tms), 64'd1);
    chk({tag, "_tdi"}, 64'(tdi), 64'd0);
    chk({tag, "_ready"}, 64'(bus.cmd_ready), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
`ifdef JTAG_TRST_EN
    chk({tag, "_trst_n"}, 64'(trst_n), 64'd0);
`endif
  endtask

  // Release reset and check the 5x tms=1, 1x tms=0 sync and ready timing.
  task automatic sync_chk(input string tag);
    int cnt;
    bit early;
    rec_n = 0; rec_tms = '0; rec_tdi = '0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    early = 1'b0;
    while (!bus.cmd_ready && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
`ifdef JTAG_TRST_EN
      if (!bus.cmd_ready && trst_n) early = 1'b1;
`endif
    end
    chk({tag, "_ready_clks"}, 64'(cnt), 64'(12 * TCK_HALF));
    chk({tag, "_tcks"}, 64'(rec_n), 64'd6);
    chk({tag, "_tms_seq"}, rec_tms, 64'h1F);
    chk({tag, "_tdi_seq"}, rec_tdi, 64'd0);
    chk({tag, "_tap_state"}, 64'(ts), 64'(T_RTI));
    exp_ir = 2'b01;
`ifdef JTAG_TRST_EN
    chk({tag, "_trst_early"}, 64'(early), 64'd0);
    chk({tag, "_trst_after"}, 64'(trst_n), 64'd1);
`endif
  endtask

  task automatic do_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                        input bit hold);
    int n, k, pre, acc, to, nacc0;
    logic [63:0] etms, etdi, mask, erx, d64, s;
    n    = (len == 0) ? 1 : (len > MAX_LEN ? MAX_LEN : len);
    mask = (64'd1 << n) - 64'd1;
    d64  = {32'd0, data} & mask;
    etms = '0; etdi = '0; erx = '0; k = 0;
    if (op == OP_RESET) begin
      etms = 64'h1F; k = 6;
    end else if (op == OP_IDLE) begin
      k = n;
    end else begin
      pre = (op == OP_SHIFT_IR) ? 2 : 1;
      for (int i = 0; i < pre; i++) begin etms[k] = 1'b1; k++; end
      k += 2;
      for (int i = 0; i < n; i++) begin
        etdi[k] = d64[i];
        if (i == n - 1) etms[k] = 1'b1;
        k++;
      end
      etms[k] = 1'b1;
      k += 2;
      if (op == OP_SHIFT_DR) erx = (d64 << 1) & mask;
      else begin
        s   = (d64 << 2) | 64'd1;
        erx = s & mask;
        exp_ir = 2'((s >> n) & 64'd3);
      end
    end
    if (op == OP_RESET) exp_ir = 2'b01;

    to = 0;
    while (!bus.cmd_ready && to < 500) begin @(posedge clk); #1; to++; end
    chk("ready_wait", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = data;
    rec_n = 0; rec_tms = '0; rec_tdi = '0;
    nacc0 = nacc;
    @(posedge clk); #1;
    acc = cyc;
    if (!hold) bus.cmd_valid = 1'b0;
    to = 0;
    while (!bus.rsp_valid && to < 2000) begin @(posedge clk); #1; to++; end
    bus.cmd_valid = 1'b0;
    chk("rsp_seen", 64'(bus.rsp_valid), 64'd1);
    chk("latency", 64'(cyc - acc), 64'(k * 2 * TCK_HALF));
    chk("ready_at_rsp", 64'(bus.cmd_ready), 64'd1);
    chk("tck_count", 64'(rec_n), 64'(k));
    chk("tms_seq", rec_tms, etms);
    chk("tdi_seq", rec_tdi, etdi);
    chk("rsp_data", 64'(bus.rsp_data), erx);
    chk("tap_state", 64'(ts), 64'(T_RTI));
    chk("tap_ir", 64'(ir), 64'(exp_ir));
    @(posedge clk); #1;
    chk("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    chk("rsp_hold", 64'(bus.rsp_data), erx);
    if (hold) chk("single_accept", 64'(nacc - nacc0), 64'd1);
  endtask

  initial begin
    int to, nrsp0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_vals("rst");
    sync_chk("sync");

    do_cmd(OP_SHIFT_IR, 2, 32'h3, 1'b0);
    do_cmd(OP_SHIFT_DR, 8, 32'hA5, 1'b0);
    do_cmd(OP_SHIFT_DR, 0, 32'hFFFF_FFFF, 1'b0);
    do_cmd(OP_SHIFT_DR, 40, $urandom, 1'b0);
    do_cmd(OP_SHIFT_IR, 0, 32'h1, 1'b0);
    do_cmd(OP_IDLE, 3, $urandom, 1'b1);
    do_cmd(OP_RESET, 7, $urandom, 1'b0);
    do_cmd(OP_SHIFT_IR, 32, $urandom, 1'b0);
    for (int i = 0; i < 16; i++)
      do_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom, 1'($urandom_range(0, 1)));

    // Abort a DR shift while bit 4 is on the wire.
    to = 0;
    while (!bus.cmd_ready && to < 500) begin @(posedge clk); #1; to++; end
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SHIFT_DR;
    bus.cmd_len   = LEN_W'(8);
    bus.cmd_data  = 32'hA5;
    rec_n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    to = 0;
    while (rec_n < 8 && to < 500) begin @(posedge clk); #1; to++; end
    chk("abort_reached", 64'(rec_n), 64'd8);
    nrsp0 = nrsp;
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst_vals("abort");
    repeat (3) @(posedge clk);
    sync_chk("resync");
    chk("abort_no_rsp", 64'(nrsp - nrsp0), 64'd0);
    do_cmd(OP_SHIFT_IR, 2, 32'h2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_host_driver.md
Name: jtag_host_driver

Overview:
- On-chip or bench-side JTAG master that drives tck, tms and tdi into a device's TAP and samples tdo.
- Executes queued commands (TAP reset, IR shift, DR shift, idle clocks) from a valid/ready command port.
- Returns captured TDO bits on a response port.
- Tester-side counterpart of the boundary-scan cells, instruction register and decode logic; used to load instructions and scan boundary/internal chains.

Parameters:
- MAX_LEN, 32: maximum shift length in bits; width of cmd_data and rsp_data.
- TCK_HALF, 2: clk cycles per tck half-period; must be >= 1.
- LEN_W (localparam): $clog2(MAX_LEN+1); not overridable.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  host can accept a command.
- cmd_op  in  2  0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE.
- cmd_len  in  LEN_W  bit count (SHIFT) or tck count (IDLE).
- cmd_data  in  MAX_LEN  TDI data, LSB shifted first.
- rsp_valid  out  1  one-clk pulse on command completion.
- rsp_data  out  MAX_LEN  captured TDO, bit0 = first captured bit, upper bits 0.
- busy  out  1  equals ~cmd_ready.
- tck  out  1  test clock.
- tms  out  1  test mode select.
- tdi  out  1  test data to device.
- tdo  in  1  test data from device.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_data=0.
- TCK timing:
  - One tck cycle is 2*TCK_HALF clk cycles.
  - tms/tdi update on the clk edge where tck falls, or on the accept edge for the first cycle.
  - tck rises TCK_HALF clks later; tdo is registered on that same clk edge.
  - tck falls TCK_HALF clks after rising.
- Post-reset sync: after rst deasserts, run 5 tck with tms=1, then 1 tck with tms=0 (TAP in Run-Test/Idle). cmd_ready rises on the edge completing tck 6, i.e. 12*TCK_HALF clk edges after the first edge following deassertion.
- FSM states:
  - SYNC: on completion -> IDLE.
  - IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready, latching op, clamped len and data -> SEL.
  - SEL: DR: tms 1; IR: tms 1,1.
  - CAP: tms 0.
  - ENTER: tms 0.
  - SHIFT: n tck cycles; tms=0 except the last, which has tms=1. tdi=data[i] for i=0..n-1. tdo captured at each rising tck into rsp bit i.
  - UPD: tms 1.
  - RET: tms 0.
  - DONE -> IDLE.
- Outside SHIFT, tdi=0.
- Op sequences from Run-Test/Idle:
  - SHIFT_DR: n+5 tck cycles.
  - SHIFT_IR: n+6 tck cycles.
  - RESET: 5×tms=1 then 1×tms=0.
  - IDLE: n×tms=0.
- Length clamp: cmd_len=0 is treated as 1; cmd_len>MAX_LEN is treated as MAX_LEN.
- Completion:
  - On the clk edge where the final tck falls: rsp_valid=1 for one clk, cmd_ready=1 the same cycle.
  - A new command may be accepted on the next edge.
  - Latency from accept edge to rsp_valid edge = (tck count)*2*TCK_HALF.
- rsp_data:
  - Updated only at completion and held until the next completion.
  - RESET and IDLE return 0.
- cmd_valid while busy is ignored; no queueing.
- rst mid-command: all outputs return to reset values immediately; no rsp_valid for the aborted command; SYNC repeats after deassertion.

Optional Feature:
- JTAG_TRST_EN defined:
  - Adds output trst_n (1 bit, active-low).
  - trst_n=0 during rst, throughout SYNC, and throughout the 6 tck cycles of a RESET op; 1 otherwise.
- Undefined: the port is absent; TAP reset relies on tms only.

Decomposition:
- Package jtag_pkg:
  - op-code constants (OP_RESET, OP_SHIFT_IR, OP_SHIFT_DR, OP_IDLE).
  - FSM state encoding.
  - RESET_TCKS=5.
- Sub-module jtag_tck_gen:
  - Counter/divider producing tck plus one-clk rise_stb and fall_stb strobes.
  - Cleared by rst; held at tck=0 with no strobes while the FSM is in IDLE.

Test Plan:
- Reset sync, TCK_HALF=2: pulse rst -> tms=1 for 5 tck, 0 for 1; cmd_ready=1 exactly 24 clks after deassertion; tdi=0 throughout.
- SHIFT_IR len=2 data=2'b11 into TAP model: tms sequence 1,1,0,0,0,1,1,0; tdi=1 in both shift cycles; rsp_valid 32 clks after accept; model IR=2'b11 after Update-IR.
- SHIFT_DR len=8 data=0xA5, model in BYPASS (1-bit reg, captures 0): rsp_data=0x4A; 13 tck cycles; rsp_valid single-cycle.
- Clamp: len=0 -> one shift bit, 6 tck; len=40 with MAX_LEN=32 -> exactly 32 shift cycles.
- IDLE len=3: tms=0, tdi=0 for 3 tck; rsp_data=0; cmd_valid held high during busy accepted only once.
- rst asserted mid SHIFT_DR bit 4: tck=0, tms=1, cmd_ready=0 the same cycle; no rsp_valid; SYNC rerun; with JTAG_TRST_EN, trst_n low through SYNC.
